rbm_iteration_scheduler: RTL and testbench

RBM_ITERATION_SCHEDULER -- requirements
Module: rbm_iteration_scheduler

---
 rtl/rbm_pkg.sv | 22 ++
 rtl/rbm_vote_accum.sv | 45 ++++
 rtl/rbm_iteration_scheduler.sv | 174 +++++++++++++++++
 tb/tb_rbm_iteration_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbm_pkg.sv
// Shared definitions for the RBM iteration scheduler: FSM state encoding,
// round-index width and the rounds-per-phase ceiling helper.
package rbm_pkg;

    localparam int GROUP_W = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_HID_ISSUE = 3'd2,
        S_HID_WAIT  = 3'd3,
        S_CL_ISSUE  = 3'd4,
        S_CL_WAIT   = 3'd5,
        S_ACCUM     = 3'd6,
        S_DONE      = 3'd7
    } sched_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/rbm_vote_accum.sv
// Saturating per-output vote counters; one counter of BITLENGTH bits per
// classifier output, packed with output 0 in the LSBs.
module rbm_vote_accum
    import rbm_pkg::*;
#(
    parameter int BITLENGTH  = 12,
    parameter int OUTPUT_DIM = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             enable,
    input  logic [OUTPUT_DIM-1:0]            sample,
    output logic [OUTPUT_DIM*BITLENGTH-1:0]  vote_count
);

    localparam logic [BITLENGTH-1:0] CNT_MAX = '1;

    logic [OUTPUT_DIM*BITLENGTH-1:0] vote_q;
    logic [OUTPUT_DIM*BITLENGTH-1:0] vote_d;

    always_comb begin
        vote_d = vote_q;
        for (int o = 0; o < OUTPUT_DIM; o++) begin
            if (clear) begin
                vote_d[o*BITLENGTH +: BITLENGTH] = '0;
            end else if (enable && sample[o] &&
                         (vote_q[o*BITLENGTH +: BITLENGTH] != CNT_MAX)) begin
                vote_d[o*BITLENGTH +: BITLENGTH] =
                    vote_q[o*BITLENGTH +: BITLENGTH] + BITLENGTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vote_q <= '0;
        end else begin
            vote_q <= vote_d;
        end
    end

    assign vote_count = vote_q;

endmodule

// File: rtl/rbm_iteration_scheduler.sv
// Sequences hidden and classifier rounds for ITERATION_NUM sampling iterations
// and accumulates output votes. Optional busy-cycle counter: RBM_SCHED_PERF_EN.
module rbm_iteration_scheduler
    import rbm_pkg::*;
#(
    parameter int BITLENGTH              = 12,
    parameter int HIDDEN_DIM             = 5,
    parameter int OUTPUT_DIM             = 2,
    parameter int HIDDEN_ADDER_GROUP_NUM = 1,
    parameter int CL_ADDER_GROUP_NUM     = 1,
    parameter int ITERATION_NUM          = 100
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            data_valid,
    output logic                            load_input,
    output logic                            hid_start,
    output logic [GROUP_W-1:0]              hid_group,
    input  logic                            hid_done,
    output logic                            cl_start,
    output logic [GROUP_W-1:0]              cl_group,
    input  logic                            cl_done,
    input  logic [OUTPUT_DIM-1:0]           cl_sample,
    output logic [15:0]                     iter_count,
    output logic [OUTPUT_DIM*BITLENGTH-1:0] vote_count,
    output logic                            busy,
    output logic                            finish
`ifdef RBM_SCHED_PERF_EN
    ,
    output logic [31:0]                     busy_cycles
`endif
);

    localparam int HR = ceil_div(HIDDEN_DIM, HIDDEN_ADDER_GROUP_NUM);
    localparam int CR = ceil_div(OUTPUT_DIM, CL_ADDER_GROUP_NUM);
    localparam logic [GROUP_W-1:0] HR_LAST     = GROUP_W'(HR - 1);
    localparam logic [GROUP_W-1:0] CR_LAST     = GROUP_W'(CR - 1);
    localparam logic [15:0]        ITER_TARGET = 16'(ITERATION_NUM);

    sched_state_e           state_q, state_d;
    logic [GROUP_W-1:0]     round_q, round_d;
    logic [15:0]            iter_q, iter_d;
    logic [OUTPUT_DIM-1:0]  cap_q, cap_d;
    logic [15:0]            iter_inc;
    logic                   acc_clear;
    logic                   acc_en;

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        iter_d    = iter_q;
        cap_d     = cap_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        iter_inc  = iter_q + 16'd1;
        case (state_q)
            S_IDLE: begin
                if (data_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_clear = 1'b1;
                iter_d    = '0;
                round_d   = '0;
                state_d   = S_HID_ISSUE;
            end
            S_HID_ISSUE: begin
                state_d = S_HID_WAIT;
            end
            S_HID_WAIT: begin
                if (hid_done) begin
                    if (round_q < HR_LAST) begin
                        round_d = round_q + GROUP_W'(1);
                        state_d = S_HID_ISSUE;
                    end else begin
                        round_d = '0;
                        state_d = S_CL_ISSUE;
                    end
                end
            end
            S_CL_ISSUE: begin
                state_d = S_CL_WAIT;
            end
            S_CL_WAIT: begin
                if (cl_done) begin
                    if (round_q < CR_LAST) begin
                        round_d = round_q + GROUP_W'(1);
                        state_d = S_CL_ISSUE;
                    end else begin
                        // only the final classifier round carries the full sample
                        cap_d   = cl_sample;
                        round_d = '0;
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                acc_en  = 1'b1;
                iter_d  = iter_inc;
                round_d = '0;
                state_d = (iter_inc == ITER_TARGET) ? S_DONE : S_HID_ISSUE;
            end
            S_DONE: begin
                if (!data_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            round_q <= '0;
            iter_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            iter_q  <= iter_d;
            cap_q   <= cap_d;
        end
    end

    rbm_vote_accum #(
        .BITLENGTH (BITLENGTH),
        .OUTPUT_DIM(OUTPUT_DIM)
    ) u_vote_accum (
        .clock     (clock),
        .reset     (reset),
        .clear     (acc_clear),
        .enable    (acc_en),
        .sample    (cap_q),
        .vote_count(vote_count)
    );

    // Outputs decode straight from the state so reset zeroes them at once.
    assign load_input = (state_q == S_LOAD);
    assign hid_start  = (state_q == S_HID_ISSUE);
    assign cl_start   = (state_q == S_CL_ISSUE);
    assign hid_group  = ((state_q == S_HID_ISSUE) || (state_q == S_HID_WAIT)) ? round_q : '0;
    assign cl_group   = ((state_q == S_CL_ISSUE) || (state_q == S_CL_WAIT)) ? round_q : '0;
    assign finish     = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign iter_count = iter_q;

`ifdef RBM_SCHED_PERF_EN
    logic [31:0] busy_cyc_q, busy_cyc_d;

    always_comb begin
        busy_cyc_d = busy_cyc_q;
        if (state_q == S_LOAD) begin
            busy_cyc_d = 32'd1;
        end else if (busy) begin
            busy_cyc_d = busy_cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_cyc_q <= '0;
        end else begin
            busy_cyc_q <= busy_cyc_d;
        end
    end

    assign busy_cycles = busy_cyc_q;
`endif

endmodule

// File: tb/tb_rbm_iteration_scheduler.sv
// Scoreboard bench for rbm_iteration_scheduler: default instance (12-bit, 100
// iterations) and a small instance (4-bit, 20 iterations).
module tb_rbm_iteration_scheduler;

    localparam int HRN = 5;
    localparam int CRN = 2;

    typedef struct {
        int iters;
        int v0;
        int v1;
        int lat;
    } exp_t;

    logic clock;
    logic reset_n    [2];
    logic data_valid [2];
    logic spur       [2];

    logic        ld  [2];
    logic        hs  [2];
    logic        cs  [2];
    logic        fin [2];
    logic        bsy [2];
    logic [7:0]  hg  [2];
    logic [7:0]  cg  [2];
    logic [15:0] itc [2];
    logic [31:0] vv0 [2];
    logic [31:0] vv1 [2];
`ifdef RBM_SCHED_PERF_EN
    logic [31:0] bcy [2];
`endif

    exp_t       exp_q [2][$];
    logic [1:0] smp_q [2][$];
    int         hq    [2][$];
    int         cq    [2][$];
    int         start_cyc [2];
    int         loads     [2];
    bit         rnd_dly   [2];
    bit         garb      [2];
    logic [1:0] fix_smp   [2];
    int         cyc;
    int         nvec;
    int         nerr;

    task automatic chk(input string nm, input longint act, input longint req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int BL = (g == 0) ? 12 : 4;
        localparam int NI = (g == 0) ? 100 : 20;

        logic          load_input, hid_start, hid_done, cl_start, cl_done_rsp, cl_done;
        logic          busy, finish;
        logic [7:0]    hid_group, cl_group;
        logic [1:0]    cl_sample;
        logic [15:0]   iter_count;
        logic [2*BL-1:0] vote;
`ifdef RBM_SCHED_PERF_EN
        logic [31:0]   busy_cycles;
`endif

        rbm_iteration_scheduler #(
            .BITLENGTH             (BL),
            .HIDDEN_DIM            (5),
            .OUTPUT_DIM            (2),
            .HIDDEN_ADDER_GROUP_NUM(1),
            .CL_ADDER_GROUP_NUM    (1),
            .ITERATION_NUM         (NI)
        ) dut (
            .clock      (clock),
            .reset      (reset_n[g]),
            .data_valid (data_valid[g]),
            .load_input (load_input),
            .hid_start  (hid_start),
            .hid_group  (hid_group),
            .hid_done   (hid_done),
            .cl_start   (cl_start),
            .cl_group   (cl_group),
            .cl_done    (cl_done),
            .cl_sample  (cl_sample),
            .iter_count (iter_count),
            .vote_count (vote),
            .busy       (busy),
            .finish     (finish)
`ifdef RBM_SCHED_PERF_EN
            ,
            .busy_cycles(busy_cycles)
`endif
        );

        assign cl_done = cl_done_rsp | spur[g];
        assign ld[g]  = load_input;
        assign hs[g]  = hid_start;
        assign cs[g]  = cl_start;
        assign fin[g] = finish;
        assign bsy[g] = busy;
        assign hg[g]  = hid_group;
        assign cg[g]  = cl_group;
        assign itc[g] = iter_count;
        assign vv0[g] = 32'(vote[BL-1:0]);
        assign vv1[g] = 32'(vote[2*BL-1:BL]);
`ifdef RBM_SCHED_PERF_EN
        assign bcy[g] = busy_cycles;
`endif

        // hidden-round responder
        initial begin
            int d;
            hid_done = 1'b0;
            forever begin
                @(negedge clock);
                if (hid_start) begin
                    d = rnd_dly[g] ? int'($urandom_range(1, 3)) : 1;
                    repeat (d) @(posedge clock);
                    #1 hid_done = 1'b1;
                    @(posedge clock);
                    #1 hid_done = 1'b0;
                end
            end
        end

        // classifier-round responder; real samples only on the last round
        initial begin
            int d;
            logic [7:0] grp;
            cl_done_rsp = 1'b0;
            cl_sample   = 2'b00;
            forever begin
                @(negedge clock);
                if (cl_start) begin
                    grp = cl_group;
                    d = rnd_dly[g] ? int'($urandom_range(1, 3)) : 1;
                    repeat (d) @(posedge clock);
                    #1;
                    if (grp == 8'(CRN - 1)) begin
                        if (smp_q[g].size() > 0) cl_sample = smp_q[g].pop_front();
                        else cl_sample = 2'b00;
                    end else begin
                        cl_sample = garb[g] ? 2'($urandom_range(0, 3)) : fix_smp[g];
                    end
                    cl_done_rsp = 1'b1;
                    @(posedge clock);
                    #1 cl_done_rsp = 1'b0;
                    cl_sample = garb[g] ? 2'($urandom_range(0, 3)) : fix_smp[g];
                end
            end
        end

        // group-sequence and pulse-width monitor
        initial begin
            bit ph, pc;
            ph = 1'b0;
            pc = 1'b0;
            forever begin
                @(negedge clock);
                if (load_input) loads[g]++;
                if (hid_start) begin
                    chk("hid_start_single_cycle", ph, 0);
                    chk("hid_start_expected", hq[g].size() > 0, 1);
                    if (hq[g].size() > 0) chk("hid_group", hid_group, hq[g].pop_front());
                end
                if (cl_start) begin
                    chk("cl_start_single_cycle", pc, 0);
                    chk("cl_start_expected", cq[g].size() > 0, 1);
                    if (cq[g].size() > 0) chk("cl_group", cl_group, cq[g].pop_front());
                end
                ph = hid_start;
                pc = cl_start;
            end
        end

        // result monitor: pops the expected record when finish rises
        initial begin
            bit pf;
            exp_t e;
            pf = 1'b0;
            forever begin
                @(negedge clock);
                if (finish && !pf) begin
                    chk("finish_expected", exp_q[g].size() > 0, 1);
                    if (exp_q[g].size() > 0) begin
                        e = exp_q[g].pop_front();
                        chk("iter_count", iter_count, e.iters);
                        chk("vote_count[0]", vv0[g], e.v0);
                        chk("vote_count[1]", vv1[g], e.v1);
                        if (e.lat >= 0) chk("latency", cyc - start_cyc[g], e.lat);
`ifdef RBM_SCHED_PERF_EN
                        chk("busy_cycles", busy_cycles, cyc - start_cyc[g] - 1);
`endif
                    end
                end
                pf = finish;
            end
        end
    end

    task automatic chk_zero(input int g);
        chk("rst load_input", ld[g], 0);
        chk("rst hid_start", hs[g], 0);
        chk("rst hid_group", hg[g], 0);
        chk("rst cl_start", cs[g], 0);
        chk("rst cl_group", cg[g], 0);
        chk("rst iter_count", itc[g], 0);
        chk("rst vote_count[0]", vv0[g], 0);
        chk("rst vote_count[1]", vv1[g], 0);
        chk("rst busy", bsy[g], 0);
        chk("rst finish", fin[g], 0);
`ifdef RBM_SCHED_PERF_EN
        chk("rst busy_cycles", bcy[g], 0);
`endif
    endtask

    task automatic start_run(input int g, input int iters, input int maxv, input bit fixed,
                             input logic [1:0] fs, input bit rnd, input bit gb, input bit want_lat);
        exp_t e;
        int a, b;
        logic [1:0] s;
        a = 0;
        b = 0;
        for (int i = 0; i < iters; i++) begin
            s = fixed ? fs : 2'($urandom_range(0, 3));
            smp_q[g].push_back(s);
            a = (a + int'(s[0]) > maxv) ? maxv : a + int'(s[0]);
            b = (b + int'(s[1]) > maxv) ? maxv : b + int'(s[1]);
            for (int r = 0; r < HRN; r++) hq[g].push_back(r);
            for (int r = 0; r < CRN; r++) cq[g].push_back(r);
        end
        e.iters = iters;
        e.v0    = a;
        e.v1    = b;
        e.lat   = want_lat ? 2 + iters * (2 * HRN + 2 * CRN + 1) : -1;
        exp_q[g].push_back(e);
        rnd_dly[g] = rnd;
        garb[g]    = gb;
        fix_smp[g] = fs;
        loads[g]   = 0;
        @(posedge clock);
        #1 data_valid[g] = 1'b1;
        start_cyc[g] = cyc;
    endtask

    task automatic finish_run(input int g, input int budget, input int iters);
        int n;
        n = 0;
        while (!fin[g] && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("finish_within_budget", fin[g], 1);
        chk("load_input_pulses", loads[g], 1);
        repeat (3) @(negedge clock);
        chk("done finish held", fin[g], 1);
        chk("done busy", bsy[g], 0);
        chk("done iter_count held", itc[g], iters);
        @(posedge clock);
        #1 data_valid[g] = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle finish", fin[g], 0);
        chk("idle busy", bsy[g], 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nvec = 0;
        nerr = 0;
        for (int g = 0; g < 2; g++) begin
            reset_n[g]    = 1'b0;
            data_valid[g] = 1'b0;
            spur[g]       = 1'b0;
            rnd_dly[g]    = 1'b0;
            garb[g]       = 1'b0;
            fix_smp[g]    = 2'b00;
            loads[g]      = 0;
            start_cyc[g]  = 0;
        end
        repeat (3) @(negedge clock);
        chk_zero(0);
        chk_zero(1);
        @(posedge clock);
        #2 reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;

        // defaults, fixed 1-cycle rounds, sample 01 every iteration
        start_run(0, 100, 4095, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        finish_run(0, 3000, 100);

        // random samples plus ignored data_valid toggle and spurious cl_done
        start_run(0, 100, 4095, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        repeat (50) @(posedge clock);
        #1 data_valid[0] = 1'b0;
        repeat (4) @(posedge clock);
        #1 data_valid[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!hs[0] && n < 100);
        chk("hid_start_seen", hs[0], 1);
        @(posedge clock);
        #1 spur[0] = 1'b1;
        @(posedge clock);
        #1 spur[0] = 1'b0;
        finish_run(0, 3000, 100);

        // random round latencies and random samples
        start_run(0, 100, 4095, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        finish_run(0, 5000, 100);

        // reset during HID_WAIT of iteration 37
        start_run(0, 100, 4095, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(itc[0] == 16'd37 && hs[0]) && n < 3000);
        chk("reached iteration 37", itc[0], 37);
        @(posedge clock);
        #2 reset_n[0] = 1'b0;
        data_valid[0] = 1'b0;
        #1 chk_zero(0);
        exp_q[0].delete();
        smp_q[0].delete();
        hq[0].delete();
        cq[0].delete();
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset_n[0] = 1'b1;
        repeat (3) @(negedge clock);
        chk_zero(0);

        // fresh run after the mid-run reset starts from iteration 0
        start_run(0, 100, 4095, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        finish_run(0, 3000, 100);

        // small instance: saturation at 15 with sample 11
        start_run(1, 20, 15, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
        finish_run(1, 1000, 20);

        // small instance: random samples and latencies
        start_run(1, 20, 15, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        finish_run(1, 1500, 20);

        repeat (3) @(negedge clock);
        chk("scoreboard drained", exp_q[0].size() + exp_q[1].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
